// File: rtl/evt_sched_if.sv
// evt_sched_if: event-pulse / grant handshake bundle between event sources,
// the scheduler and its shared consumer.
//   slave  - scheduler side (takes events and ack, drives the grant)
//   master - environment side (drives events and ack, observes the grant)
interface evt_sched_if;
  logic [3:0] pi_req;
  logic       pi_ack;
  logic       po_vld;
  logic [1:0] po_id;
  logic [3:0] po_ovf;
  logic       po_busy;

  modport slave (
    input  pi_req, pi_ack,
    output po_vld, po_id, po_ovf, po_busy
  );

  modport master (
    output pi_req, pi_ack,
    input  po_vld, po_id, po_ovf, po_busy
  );
endinterface

// File: rtl/evt_sched.sv
// evt_sched: counts event pulses from four sources and serialises them as
// grants to one shared consumer.
//
// Each grant is held until the consumer acks it. After an accepted grant the
// scheduler idles for GAP cycles. Counters saturate, and each overflow sets a
// sticky flag.
//
// Build option EVT_SCHED_RR_EN:
//   defined   - round-robin arbitration
//   undefined - fixed priority, where the lowest index wins
module evt_sched #(
  parameter int CNT_W = 3,  // pending counter width (2..6)
  parameter int GAP   = 2   // idle cycles after each accepted grant (0..15)
) (
  input  logic        sclk,
  input  logic        s_rst,
  evt_sched_if.slave  bus
);

  // One-hot state encoding; any other pattern is treated as illegal.
  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_GRANT = 3'b010;
  localparam logic [2:0] S_GAP   = 3'b100;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic [1:0]       id_q, id_d;
  logic [3:0]       gap_q, gap_d;
  logic             acc;
  logic             any_pend;
  logic [1:0]       sel_id;
`ifdef EVT_SCHED_RR_EN
  logic [1:0]       ptr_q, ptr_d;
`endif

  // A grant is accepted only while it is actually presented.
  assign acc = vld_q & bus.pi_ack;

  // Arbiter: pick the source for the next grant from the current counters.
  always_comb begin
    // NOTE: default every always_comb output up front so no path infers a latch.
    sel_id   = '0;
    any_pend = 1'b0;
    // Descending scan: the last hit, the one closest to the search start, wins.
    for (int k = 3; k >= 0; k--) begin
`ifdef EVT_SCHED_RR_EN
      if (cnt_q[ptr_q + 2'(k)] != '0) begin
        sel_id   = ptr_q + 2'(k);
        any_pend = 1'b1;
      end
`else
      if (cnt_q[k] != '0) begin
        sel_id   = 2'(k);
        any_pend = 1'b1;
      end
`endif
    end
  end

  // Pending counters: +1 per event, -1 per accepted grant, saturating at the top.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.pi_req[i] && !(acc && id_q == 2'(i))) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;  // event dropped
        else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (!bus.pi_req[i] && acc && id_q == 2'(i)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  // Grant FSM: idle -> present grant until acked -> optional gap -> idle.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    id_d    = id_q;
    gap_d   = gap_q;
`ifdef EVT_SCHED_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_pend) begin
          state_d = S_GRANT;
          vld_d   = 1'b1;
          id_d    = sel_id;
        end
      end
      S_GRANT: begin
        if (acc) begin
          vld_d = 1'b0;
`ifdef EVT_SCHED_RR_EN
          ptr_d = id_q + 2'd1;
`endif
          if (GAP > 0) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
        gap_d   = 4'd0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge sclk) begin
    // NOTE: non-blocking assignments in clocked logic, so every flop samples pre-edge values.
    if (s_rst) begin
      state_q <= S_IDLE;
      ovf_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      gap_q   <= '0;
      // NOTE: the counter array is reset explicitly because the reset discards pending events.
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
`ifdef EVT_SCHED_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      gap_q   <= gap_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
`ifdef EVT_SCHED_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.po_vld  = vld_q;
  assign bus.po_id   = id_q;
  assign bus.po_ovf  = ovf_q;
  assign bus.po_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_evt_sched.sv
// tb_evt_sched: self-checking bench for evt_sched (default CNT_W=3, GAP=2).
// Expected grant ids are queued when events are driven and popped by a
// monitor whenever a grant is accepted.
module tb_evt_sched;

  logic sclk;
  logic s_rst;
  int   checks   = 0;
  int   failures = 0;
  int   exp_q [$];

  evt_sched_if bus_if ();

  evt_sched #(.CNT_W(3), .GAP(2)) dut (
    .sclk  (sclk),
    .s_rst (s_rst),
    .bus   (bus_if)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Scoreboard monitor: every accepted grant must match the next queued id.
  always @(negedge sclk) begin
    if (!s_rst && bus_if.po_vld === 1'b1 && bus_if.pi_ack === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL grant_order: accepted id %0d, expected no grant", bus_if.po_id);
      end else begin
        int exp_id;
        exp_id = exp_q.pop_front();
        if (bus_if.po_id !== 2'(exp_id)) begin
          failures++;
          $display("FAIL grant_order: accepted id %0d, expected %0d", bus_if.po_id, exp_id);
        end
      end
    end
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    bus_if.pi_req = 4'b0000;
    step();
    s_rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected grants never accepted, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    s_rst = 1'b1;
    bus_if.pi_req = 4'b1111;  // must be ignored while in reset
    bus_if.pi_ack = 1'b1;
    step();
    step();
    checks++;
    if ({bus_if.po_vld, bus_if.po_id, bus_if.po_ovf, bus_if.po_busy} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: vld=%b id=%0d ovf=%b busy=%b, expected all zero",
               bus_if.po_vld, bus_if.po_id, bus_if.po_ovf, bus_if.po_busy);
    end
    s_rst = 1'b0;
    bus_if.pi_req = 4'b0000;
    for (int c = 1; c <= 6; c++) begin
      step();
      checks++;
      if (bus_if.po_vld !== 1'b0 || bus_if.po_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_req_ignored c%0d: vld=%b busy=%b, expected 0 0",
                 c, bus_if.po_vld, bus_if.po_busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus_if.pi_ack = 1'b1;
    bus_if.pi_req = 4'b0100;
    exp_q.push_back(2);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) bus_if.pi_req = 4'b0000;
      checks++;
      if (bus_if.po_vld !== (c == 2)) begin
        failures++;
        $display("FAIL single_vld c%0d: vld=%b, expected %b", c, bus_if.po_vld, (c == 2));
      end
      if (c == 2) begin
        checks++;
        if (bus_if.po_id !== 2'd2) begin
          failures++;
          $display("FAIL single_id: id=%0d, expected 2", bus_if.po_id);
        end
      end
      if (c == 3 || c == 10) begin
        checks++;
        if (bus_if.po_busy !== (c == 3)) begin
          failures++;
          $display("FAIL single_busy c%0d: busy=%b, expected %b", c, bus_if.po_busy, (c == 3));
        end
      end
    end
    check_queue_empty("single_drain");
  endtask

  task automatic test_all_four();
    do_reset();
    bus_if.pi_ack = 1'b1;
    bus_if.pi_req = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 1) bus_if.pi_req = 4'b0000;
      checks++;
      if (bus_if.po_vld !== (c == 2 || c == 6 || c == 10 || c == 14)) begin
        failures++;
        $display("FAIL all_four_spacing c%0d: vld=%b, expected %b", c, bus_if.po_vld,
                 (c == 2 || c == 6 || c == 10 || c == 14));
      end
    end
    check_queue_empty("all_four_drain");
  endtask

  task automatic test_contention();
    do_reset();
    bus_if.pi_ack = 1'b1;
    bus_if.pi_req = 4'b0011;
`ifdef EVT_SCHED_RR_EN
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
`else
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
`endif
    for (int c = 1; c <= 11; c++) begin
      step();
      checks++;
      if (bus_if.po_vld !== (c == 2 || c == 6 || c == 10)) begin
        failures++;
        $display("FAIL contention_vld c%0d: vld=%b, expected %b", c, bus_if.po_vld,
                 (c == 2 || c == 6 || c == 10));
      end
    end
    bus_if.pi_req = 4'b0000;
    bus_if.pi_ack = 1'b0;
    check_queue_empty("contention_drain");
  endtask

  task automatic test_overflow_reset();
    do_reset();
    bus_if.pi_ack = 1'b0;
    bus_if.pi_req = 4'b1000;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 8) bus_if.pi_req = 4'b0000;
      if (c >= 2) begin
        checks++;
        if (bus_if.po_vld !== 1'b1 || bus_if.po_id !== 2'd3) begin
          failures++;
          $display("FAIL ovf_hold c%0d: vld=%b id=%0d, expected 1 3", c, bus_if.po_vld, bus_if.po_id);
        end
      end
      if (c >= 7) begin
        checks++;
        if (bus_if.po_ovf !== ((c >= 8) ? 4'b1000 : 4'b0000)) begin
          failures++;
          $display("FAIL ovf_flag c%0d: ovf=%b, expected %b", c, bus_if.po_ovf,
                   ((c >= 8) ? 4'b1000 : 4'b0000));
        end
      end
    end
    // Reset in the middle of a presented grant with counters still pending.
    s_rst = 1'b1;
    step();
    checks++;
    if (bus_if.po_vld !== 1'b0 || bus_if.po_busy !== 1'b0 || bus_if.po_ovf !== 4'b0000) begin
      failures++;
      $display("FAIL mid_grant_reset: vld=%b busy=%b ovf=%b, expected 0 0 0000",
               bus_if.po_vld, bus_if.po_busy, bus_if.po_ovf);
    end
    s_rst = 1'b0;
    bus_if.pi_ack = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step();
      checks++;
      if (bus_if.po_vld !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle c%0d: vld=%b, expected 0", c, bus_if.po_vld);
      end
    end
  endtask

  task automatic test_coincident();
    do_reset();
    bus_if.pi_ack = 1'b1;
    bus_if.pi_req = 4'b0010;
    exp_q.push_back(1);
    exp_q.push_back(1);
    for (int c = 1; c <= 12; c++) begin
      step();
      bus_if.pi_req = (c == 2) ? 4'b0010 : 4'b0000;  // event lands on the accept cycle
      checks++;
      if (bus_if.po_vld !== (c == 2 || c == 6)) begin
        failures++;
        $display("FAIL coincident_vld c%0d: vld=%b, expected %b", c, bus_if.po_vld,
                 (c == 2 || c == 6));
      end
    end
    check_queue_empty("coincident_drain");
  endtask

  initial begin
    s_rst = 1'b1;
    bus_if.pi_req = 4'b0000;
    bus_if.pi_ack = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_contention();
    test_overflow_reset();
    test_coincident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/evt_sched.md
EVT_SCHED -- requirements
Module: evt_sched

Interface
REQ-001 Parameter: CNT_W, default 3, width of each per-source pending-event counter (legal 2..6).
REQ-002 Parameter: GAP, default 2, idle cycles enforced after each accepted grant (legal 0..15).
REQ-003 Port: sclk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: s_rst  in  1  reset, synchronous, active-high.
REQ-005 Port: pi_req  in  4  per-source event pulses, one event per high cycle per bit (k1/k2-style key-FSM outputs).
REQ-006 Port: pi_ack  in  1  consumer accepts the presented grant this cycle.
REQ-007 Port: po_vld  out  1  grant presented to the shared consumer.
REQ-008 Port: po_id  out  2  index of the granted source; meaningful only while po_vld=1.
REQ-009 Port: po_ovf  out  4  sticky per-source overflow flags.
REQ-010 Port: po_busy  out  1  high whenever the FSM is not in S_IDLE.

Function
REQ-011 Per source i, the pending counter SHALL +1 on pi_req[i] and -1 on accepted grant (po_vld & pi_ack & po_id==i); both in the same cycle -> counter unchanged.
REQ-012 A counter at 2^CNT_W-1 receiving pi_req[i] without a same-cycle decrement SHALL stay saturated and set po_ovf[i]; the event is dropped.
REQ-013 po_ovf bits SHALL clear only on reset.
REQ-014 FSM states SHALL be S_IDLE, S_GRANT, S_GAP, one-hot encoded; an illegal encoding SHALL return to S_IDLE on the next cycle.
REQ-015 S_IDLE: if any counter is nonzero, the arbiter SHALL select a source, register po_id, and enter S_GRANT with po_vld=1 the next cycle; otherwise remain.
REQ-016 S_GRANT: po_vld and po_id SHALL hold stable until pi_ack=1; pi_ack while po_vld=0 SHALL be ignored.
REQ-017 On accepted grant: if GAP>0, enter S_GAP with po_vld=0; if GAP=0, enter S_IDLE.
REQ-018 S_GAP SHALL last exactly GAP cycles, then enter S_IDLE; pending events arriving meanwhile SHALL only be counted.
REQ-019 Latency: pi_req[i] in cycle t with all counters previously zero and FSM in S_IDLE -> po_vld=1, po_id=i in cycle t+2.
REQ-020 Minimum spacing between consecutive accepted grants SHALL be GAP+2 cycles.
REQ-021 po_busy SHALL be combinationally derived from state; all other outputs registered.

Reset
REQ-022 While s_rst=1 at a clock edge: state=S_IDLE, all counters=0, po_vld=0, po_id=0, po_ovf=0, GAP counter=0, round-robin pointer=0.
REQ-023 Reset asserted mid-grant SHALL drop the grant (po_vld=0 next cycle) and discard all pending events; pi_req in the reset cycle SHALL be ignored.

Configuration
REQ-024 Macro EVT_SCHED_RR_EN defined: round-robin arbitration, search starting at (last granted index +1) mod 4, pointer updated only on accepted grant.
REQ-025 Macro EVT_SCHED_RR_EN undefined: fixed priority, lowest nonzero index wins; no pointer register exists.

Verification
REQ-026 Single pi_req[2] pulse after reset, pi_ack tied 1 -> po_vld=1, po_id=2 exactly 2 cycles later for one cycle; counter[2] returns to 0.
REQ-027 pi_req=4'b1111 for one cycle, pi_ack=1, GAP=2 -> grants id 0,1,2,3 each 4 cycles apart (RR_EN on or off).
REQ-028 RR_EN on: source 0 and 1 pulsing every cycle -> grants alternate 0,1,0,1; RR_EN off -> only 0 granted until counter[0]=0.
REQ-029 CNT_W=3, pi_ack=0, 8 pulses on pi_req[3] -> counter[3]=7, po_ovf[3]=1 after the 8th, po_vld held with po_id=3.
REQ-030 s_rst=1 for one cycle while po_vld=1 with counters nonzero -> next cycle po_vld=0, po_busy=0, po_ovf=0, no further grants.
REQ-031 pi_req[1] coincident with accepted grant of id 1 (counter 1) -> counter stays 1, second grant issued after GAP.
